// File: rtl/gmii_tx_sched.sv
// gmii_tx_sched: strict-priority egress scheduler sharing one GMII transmit port.
// Grants whole frames, adds preamble/SFD and the inter-frame gap, and counts underruns.
module gmii_tx_sched #(
  parameter int NUM_SRC   = 2,
  parameter int PRE_BYTES = 7,
  parameter int IFG_BYTES = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 port_en,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [7:0]           gmii_txd,
  output logic                 gmii_tx_en,
  output logic                 gmii_tx_er,
  output logic                 tx_sof,
  output logic [1:0]           tx_grant_id,
  output logic                 busy,
  output logic [15:0]          underrun_cnt
);

  localparam int CNT_MAX = (PRE_BYTES > IFG_BYTES) ? PRE_BYTES : IFG_BYTES;
  localparam int CW      = ($clog2(CNT_MAX + 1) > 4) ? $clog2(CNT_MAX + 1) : 4;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PRE   = 3'd1;
  localparam logic [2:0] SFD   = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] IFG   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    grant_q, grant_d;
  logic [7:0]    txd_q, txd_d;
  logic          txen_q, txen_d;
  logic          txer_q, txer_d;
  logic          sof_q, sof_d;
  logic [15:0]   ucnt_q, ucnt_d;

  logic          reqAny;
  logic [1:0]    reqIdx;
  logic          gValid, gLast;
  logic [7:0]    gData;
  logic          xferOpen;
  logic          arb;

  // Lowest valid index wins; scanning downward lets the last hit be the winner.
  always_comb begin
    reqIdx = 2'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_valid[i]) reqIdx = 2'(i);
    end
  end

  assign reqAny = port_en & (|src_valid);

  always_comb begin
    gValid = 1'b0;
    gLast  = 1'b0;
    gData  = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == 2'(i)) begin
        gValid = src_valid[i];
        gLast  = src_last[i];
        gData  = src_data[8*i +: 8];
      end
    end
  end

  assign xferOpen = (state_q == SFD) || (state_q == DATA) || (state_q == DRAIN);

  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = xferOpen && (grant_q == 2'(i));
    end
  end

  // Outputs are registered from the next-state decision so txd tracks the state one cycle later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    ucnt_d  = ucnt_q;
    txd_d   = 8'h00;
    txen_d  = 1'b0;
    txer_d  = 1'b0;
    sof_d   = 1'b0;
    arb     = 1'b0;

    case (state_q)
      IDLE: arb = 1'b1;
      PRE: begin
        txen_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = SFD;
          txd_d   = 8'hD5;
          sof_d   = 1'b1;
        end else begin
          txd_d = 8'h55;
          cnt_d = cnt_q - CW'(1);
        end
      end
      SFD, DATA: begin
        txen_d = 1'b1;
        if (gValid) begin
          txd_d = gData;
          if (gLast) begin
            state_d = IFG;
            cnt_d   = CW'(IFG_BYTES);
          end else begin
            state_d = DATA;
          end
        end else begin
          txer_d  = 1'b1;
          state_d = DRAIN;
          if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
        end
      end
      DRAIN: begin
        // The error cycle already went out, so the gap is counted from the last discarded byte.
        if (gValid && gLast) begin
          state_d = IFG;
          cnt_d   = CW'(IFG_BYTES - 1);
        end
      end
      IFG: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          arb     = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb && reqAny) begin
      grant_d = reqIdx;
      state_d = PRE;
      cnt_d   = CW'(PRE_BYTES - 1);
      txd_d   = 8'h55;
      txen_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= 2'd0;
      ucnt_q  <= 16'd0;
      txd_q   <= 8'h00;
      txen_q  <= 1'b0;
      txer_q  <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ucnt_q  <= ucnt_d;
      txd_q   <= txd_d;
      txen_q  <= txen_d;
      txer_q  <= txer_d;
      sof_q   <= sof_d;
    end
  end

  assign gmii_txd     = txd_q;
  assign gmii_tx_en   = txen_q;
  assign gmii_tx_er   = txer_q;
  assign tx_sof       = sof_q;
  assign tx_grant_id  = grant_q;
  assign busy         = (state_q != IDLE);
  assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_gmii_tx_sched.sv
// tb_gmii_tx_sched: directed, table-driven bench for gmii_tx_sched.
// Behavioural byte sources feed the DUT; a per-cycle trace is compared against hand-built vectors.
module tb_gmii_tx_sched;

  localparam int NS   = 2;
  localparam int TLEN = 1024;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            port_en;
  logic [NS-1:0]   src_valid;
  logic [8*NS-1:0] src_data;
  logic [NS-1:0]   src_last;
  logic [NS-1:0]   src_ready;
  logic [7:0]      gmii_txd;
  logic            gmii_tx_en;
  logic            gmii_tx_er;
  logic            tx_sof;
  logic [1:0]      tx_grant_id;
  logic            busy;
  logic [15:0]     underrun_cnt;

  gmii_tx_sched #(.NUM_SRC(NS), .PRE_BYTES(7), .IFG_BYTES(12)) dut (
    .clk(clk), .rst_n(rst_n), .port_en(port_en),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er), .tx_sof(tx_sof),
    .tx_grant_id(tx_grant_id), .busy(busy), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int checks;
  int errors;
  int cyc;
  logic clrCyc;

  int sStart[NS];
  int sLen[NS];
  int sDropAt[NS];
  int sDropLen[NS];
  logic [7:0] sBase[NS];
  int sPos[NS];
  int sDropCnt[NS];

  logic        trEn[TLEN];
  logic        trEr[TLEN];
  logic        trSof[TLEN];
  logic [7:0]  trD[TLEN];
  logic [1:0]  trGid[TLEN];
  logic [NS-1:0] trRdy[TLEN];
  logic        trBusy[TLEN];
  logic [15:0] trUcnt[TLEN];

  typedef struct {
    int         cyc;
    logic       en;
    logic       er;
    logic       sof;
    logic [7:0] d;
    int         gid;
    int         rdy;
  } vec_t;

  vec_t vecs[$];

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      if (clrCyc) cyc = 0;
      else cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cyc < TLEN) begin
        trEn[cyc]   = gmii_tx_en;
        trEr[cyc]   = gmii_tx_er;
        trSof[cyc]  = tx_sof;
        trD[cyc]    = gmii_txd;
        trGid[cyc]  = tx_grant_id;
        trRdy[cyc]  = src_ready;
        trBusy[cyc] = busy;
        trUcnt[cyc] = underrun_cnt;
      end
    end
  end

  // Sources: handshake seen at the negedge, next byte presented just after the posedge.
  initial begin
    logic [NS-1:0] acc;
    src_valid = '0;
    src_data  = '0;
    src_last  = '0;
    for (int i = 0; i < NS; i++) begin
      sPos[i] = 0;
      sDropCnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      acc = src_valid & src_ready & {NS{rst_n}};
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (clrCyc) begin
          sPos[i] = 0;
          sDropCnt[i] = 0;
        end else if (acc[i]) begin
          sPos[i]++;
        end
        src_valid[i] = 1'b0;
        src_last[i]  = 1'b0;
        src_data[8*i +: 8] = 8'h00;
        if (!clrCyc && cyc >= sStart[i] && sPos[i] < sLen[i]) begin
          if (sPos[i] == sDropAt[i] && sDropCnt[i] < sDropLen[i]) begin
            sDropCnt[i]++;
          end else begin
            src_valid[i] = 1'b1;
            src_data[8*i +: 8] = sBase[i] + 8'(sPos[i]);
            src_last[i] = (sPos[i] == sLen[i] - 1);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void addVec(int c, logic en, logic er, logic sof, logic [7:0] d, int gid, int rdy);
    vec_t v;
    v.cyc = c; v.en = en; v.er = er; v.sof = sof; v.d = d; v.gid = gid; v.rdy = rdy;
    vecs.push_back(v);
  endfunction

  // Request sampled at cycle t: 7 preamble bytes, then SFD with ready raised for the winner.
  function automatic void addPreamble(int t, int gid);
    for (int k = 1; k <= 7; k++) addVec(t + k, 1'b1, 1'b0, 1'b0, 8'h55, gid, 0);
    addVec(t + 8, 1'b1, 1'b0, 1'b1, 8'hD5, gid, 1 << gid);
  endfunction

  function automatic void addData(int c0, int n, logic [7:0] base, int gid);
    for (int k = 0; k < n; k++) addVec(c0 + k, 1'b1, 1'b0, 1'b0, base + 8'(k), gid, -1);
  endfunction

  function automatic void addIdle(int c0, int c1, int gid, int rdy);
    for (int c = c0; c <= c1; c++) addVec(c, 1'b0, 1'b0, 1'b0, 8'h00, gid, rdy);
  endfunction

  task automatic checkValue(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(string tag, vec_t v);
    int c;
    c = v.cyc;
    checks++;
    if ({trEn[c], trEr[c], trSof[c], trD[c]} !== {v.en, v.er, v.sof, v.d}) begin
      errors++;
      $display("[TB] FAIL %s cyc %0d: got en=%b er=%b sof=%b txd=%02h, expected en=%b er=%b sof=%b txd=%02h",
               tag, c, trEn[c], trEr[c], trSof[c], trD[c], v.en, v.er, v.sof, v.d);
    end
    if (v.gid >= 0) begin
      checks++;
      if (trGid[c] !== 2'(v.gid)) begin
        errors++;
        $display("[TB] FAIL %s grant cyc %0d: got %0d, expected %0d", tag, c, trGid[c], v.gid);
      end
    end
    if (v.rdy >= 0) begin
      checks++;
      if (trRdy[c] !== NS'(v.rdy)) begin
        errors++;
        $display("[TB] FAIL %s ready cyc %0d: got %b, expected %b", tag, c, trRdy[c], NS'(v.rdy));
      end
    end
  endtask

  task automatic runTable(string tag);
    foreach (vecs[i]) checkOutput(tag, vecs[i]);
    vecs.delete();
  endtask

  task automatic waitCycle(int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic resetDut();
    clrCyc = 1'b1;
    rst_n  = 1'b0;
    for (int i = 0; i < NS; i++) begin
      sStart[i] = 1000000; sLen[i] = 0; sDropAt[i] = -1; sDropLen[i] = 0; sBase[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    clrCyc = 1'b0;
    rst_n  = 1'b1;
  endtask

  task automatic applyStimulus(int src, int start, int len, logic [7:0] base, int dropAt, int dropLen);
    sStart[src] = start; sLen[src] = len; sBase[src] = base;
    sDropAt[src] = dropAt; sDropLen[src] = dropLen;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    port_en = 1'b0;
    rst_n   = 1'b0;
    clrCyc  = 1'b1;
    for (int i = 0; i < NS; i++) begin
      sStart[i] = 1000000; sLen[i] = 0; sDropAt[i] = -1; sDropLen[i] = 0; sBase[i] = 8'h00;
    end

    // Reset state.
    resetDut();
    #1;
    checkValue("reset tx_en", 32'(gmii_tx_en), 0);
    checkValue("reset txd", 32'(gmii_txd), 0);
    checkValue("reset tx_er", 32'(gmii_tx_er), 0);
    checkValue("reset sof", 32'(tx_sof), 0);
    checkValue("reset grant", 32'(tx_grant_id), 0);
    checkValue("reset busy", 32'(busy), 0);
    checkValue("reset ucnt", 32'(underrun_cnt), 0);
    checkValue("reset ready", 32'(src_ready), 0);

    // Single 64-byte frame from source 1, request sampled at cycle 10.
    resetDut();
    port_en = 1'b1;
    applyStimulus(1, 10, 64, 8'h00, -1, 0);
    addVec(10, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    addPreamble(10, 1);
    addData(19, 64, 8'h00, 1);
    addIdle(83, 94, 1, 0);
    waitCycle(100);
    runTable("single");
    checkValue("single busy@10", 32'(trBusy[10]), 0);
    checkValue("single busy@11", 32'(trBusy[11]), 1);
    checkValue("single busy@94", 32'(trBusy[94]), 1);
    checkValue("single busy@96", 32'(trBusy[96]), 0);

    // Simultaneous requests: source 0 first, exactly 12 idle cycles, then source 1.
    resetDut();
    applyStimulus(0, 5, 10, 8'hA0, -1, 0);
    applyStimulus(1, 5, 10, 8'hB0, -1, 0);
    addPreamble(5, 0);
    addData(14, 10, 8'hA0, 0);
    addIdle(24, 35, 0, 0);
    addPreamble(35, 1);
    addData(44, 10, 8'hB0, 1);
    addIdle(54, 58, 1, 0);
    waitCycle(60);
    runTable("priority");
    checkValue("priority src1 blocked", 32'(trRdy[15]), 32'h1);

    // No preemption: source 0 shows up during byte 5 of a 60-byte source 1 frame.
    resetDut();
    applyStimulus(1, 5, 60, 8'h10, -1, 0);
    applyStimulus(0, 18, 8, 8'hC0, -1, 0);
    addPreamble(5, 1);
    addData(14, 60, 8'h10, 1);
    addIdle(74, 85, 1, 0);
    addPreamble(85, 0);
    addData(94, 8, 8'hC0, 0);
    addIdle(102, 105, 0, 0);
    waitCycle(110);
    runTable("nopreempt");

    // Underrun at byte 20 of 40: error cycle, drain with ready high, 12-cycle gap after drain.
    resetDut();
    applyStimulus(1, 5, 40, 8'h20, 20, 3);
    applyStimulus(0, 40, 4, 8'hD0, -1, 0);
    addPreamble(5, 1);
    addData(14, 20, 8'h20, 1);
    addVec(34, 1'b1, 1'b1, 1'b0, 8'h00, 1, 2);
    addIdle(35, 55, 1, 2);
    addIdle(56, 67, 1, 0);
    addPreamble(67, 0);
    addData(76, 4, 8'hD0, 0);
    addIdle(80, 84, 0, 0);
    waitCycle(90);
    runTable("underrun");
    checkValue("underrun ucnt@33", 32'(trUcnt[33]), 0);
    checkValue("underrun ucnt@34", 32'(trUcnt[34]), 1);
    checkValue("underrun ucnt@84", 32'(trUcnt[84]), 1);

    // port_en low holds off a pending request; raising it starts preamble one cycle after sampling.
    resetDut();
    port_en = 1'b0;
    applyStimulus(0, 2, 8, 8'h60, -1, 0);
    for (int c = 2; c <= 102; c += 10) addVec(c, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    waitCycle(102);
    port_en = 1'b1;
    addPreamble(102, 0);
    addData(111, 8, 8'h60, 0);
    addIdle(119, 122, 0, 0);
    waitCycle(125);
    runTable("porten");
    checkValue("porten ucnt cleared", 32'(trUcnt[1]), 0);
    checkValue("porten busy@102", 32'(trBusy[102]), 0);

    // One-byte frame, then a second frame after exactly 12 idle cycles.
    resetDut();
    applyStimulus(0, 5, 1, 8'h77, -1, 0);
    applyStimulus(1, 5, 3, 8'h90, -1, 0);
    addPreamble(5, 0);
    addVec(14, 1'b1, 1'b0, 1'b0, 8'h77, 0, 0);
    addIdle(15, 26, 0, 0);
    addPreamble(26, 1);
    addData(35, 3, 8'h90, 1);
    addIdle(38, 40, 1, 0);
    waitCycle(45);
    runTable("onebyte");

    // Reset during DATA: outputs drop at once, pending source 0 is granted right after release.
    resetDut();
    applyStimulus(1, 3, 30, 8'h40, -1, 0);
    applyStimulus(0, 15, 6, 8'hE0, -1, 0);
    waitCycle(20);
    checkValue("midreset en before", 32'(trEn[19]), 1);
    rst_n = 1'b0;
    #1;
    checkValue("midreset tx_en", 32'(gmii_tx_en), 0);
    checkValue("midreset ready", 32'(src_ready), 0);
    checkValue("midreset busy", 32'(busy), 0);
    waitCycle(21);
    @(negedge clk);
    rst_n = 1'b1;
    addVec(20, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    addVec(21, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    addPreamble(21, 0);
    addData(30, 6, 8'hE0, 0);
    addIdle(36, 40, 0, 0);
    waitCycle(45);
    runTable("midreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
